// File: rtl/or4_x1_pkg.sv
// Shared types and helpers for the OR4 edge-event block.
package or4_x1_pkg;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    // Compare the current and previous level to classify a transition.
    function automatic edge_t detect_edge(input logic cur, input logic prev);
        edge_t e;
        e.rise = cur & ~prev;
        e.fall = ~cur & prev;
        return e;
    endfunction

endpackage

// File: rtl/or4_x1_evt.sv
// Edge detector, saturating rise counter and sticky-high flag for a registered level.
module or4_x1_evt
    import or4_x1_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             d,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] cnt,
    output logic             seen
);

    logic             zn_d;
    edge_t            edge_now;
    logic [CNT_W-1:0] cnt_d;
    logic             seen_d;

    // clr wins over a same-cycle increment or set.
    always_comb begin
        edge_now = detect_edge(d, zn_d);
        cnt_d    = cnt;
        seen_d   = seen | d;
        if (clr) begin
            cnt_d  = '0;
            seen_d = 1'b0;
        end else if (rise && (cnt != {CNT_W{1'b1}})) begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zn_d <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            cnt  <= '0;
            seen <= 1'b0;
        end else begin
            zn_d <= d;
            rise <= edge_now.rise;
            fall <= edge_now.fall;
            cnt  <= cnt_d;
            seen <= seen_d;
        end
    end

endmodule

// File: rtl/or4_x1.sv
// 4-input OR with a registered copy and edge/event tracking of that copy.
module or4_x1 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A1,
    input  logic             A2,
    input  logic             A3,
    input  logic             A4,
    input  logic             clr,
    output logic             ZN,
    output logic             zn_q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             seen_high
);

    // Purely combinational: valid with the clock stopped and during reset.
    assign ZN = A1 | A2 | A3 | A4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zn_q <= 1'b0;
        end else begin
            zn_q <= ZN;
        end
    end

    or4_x1_evt #(
        .CNT_W(CNT_W)
    ) u_evt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .d    (zn_q),
        .rise (rise),
        .fall (fall),
        .cnt  (rise_cnt),
        .seen (seen_high)
    );

endmodule

// File: tb/tb_or4_x1.sv
// Directed bench for or4_x1: truth table, latency, saturation, clear priority and reset.
module tb_or4_x1;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [3:0] a;
    logic       clr;

    logic       zn8, znq8, rise8, fall8, seen8;
    logic [7:0] cnt8;
    logic       zn2, znq2, rise2, fall2, seen2;
    logic [1:0] cnt2;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [3:0] a;
        logic       zn;
    } vec_t;

    or4_x1 #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .A1(a[3]), .A2(a[2]), .A3(a[1]), .A4(a[0]),
        .clr(clr),
        .ZN(zn8), .zn_q(znq8), .rise(rise8), .fall(fall8),
        .rise_cnt(cnt8), .seen_high(seen8)
    );

    or4_x1 #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .A1(a[3]), .A2(a[2]), .A3(a[1]), .A4(a[0]),
        .clr(clr),
        .ZN(zn2), .zn_q(znq2), .rise(rise2), .fall(fall2),
        .rise_cnt(cnt2), .seen_high(seen2)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    // Advance one rising edge and sample just after it; rise/fall must never coincide.
    task automatic tick();
        @(posedge clk);
        #1;
        check("rise_fall_excl", {31'b0, rise8 & fall8}, 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    vec_t tt[16];

    initial begin
        tt[0]  = '{4'b0000, 1'b0}; tt[1]  = '{4'b0001, 1'b1};
        tt[2]  = '{4'b0010, 1'b1}; tt[3]  = '{4'b0011, 1'b1};
        tt[4]  = '{4'b0100, 1'b1}; tt[5]  = '{4'b0101, 1'b1};
        tt[6]  = '{4'b0110, 1'b1}; tt[7]  = '{4'b0111, 1'b1};
        tt[8]  = '{4'b1000, 1'b1}; tt[9]  = '{4'b1001, 1'b1};
        tt[10] = '{4'b1010, 1'b1}; tt[11] = '{4'b1011, 1'b1};
        tt[12] = '{4'b1100, 1'b1}; tt[13] = '{4'b1101, 1'b1};
        tt[14] = '{4'b1110, 1'b1}; tt[15] = '{4'b1111, 1'b1};

        clk = 0; clk_en = 0; rst_n = 1; a = 4'b0000; clr = 0;
        #1 rst_n = 0;
        #1;
        check("reset_zn_q", {31'b0, znq8}, 32'd0);
        check("reset_rise", {31'b0, rise8}, 32'd0);
        check("reset_fall", {31'b0, fall8}, 32'd0);
        check("reset_cnt", {24'b0, cnt8}, 32'd0);
        check("reset_seen", {31'b0, seen8}, 32'd0);

        // Clock idle and reset held: ZN still follows the inputs.
        for (int i = 0; i < 16; i++) begin
            a = tt[i].a;
            #10;
            check($sformatf("truth_%b", tt[i].a), {31'b0, zn8}, {31'b0, tt[i].zn});
        end

        // Latency 0000 -> 0100 -> 0000
        a = 4'b0000;
        #2 rst_n = 1;
        #2 clk_en = 1;
        ticks(2);
        check("idle_zn_q", {31'b0, znq8}, 32'd0);
        a = 4'b0100;
        tick();
        check("lat_zn_q_e1", {31'b0, znq8}, 32'd1);
        check("lat_rise_e1", {31'b0, rise8}, 32'd0);
        tick();
        check("lat_rise_e2", {31'b0, rise8}, 32'd1);
        check("lat_seen_e2", {31'b0, seen8}, 32'd1);
        a = 4'b0000;
        tick();
        check("lat_zn_q_e3", {31'b0, znq8}, 32'd0);
        check("lat_rise_e3", {31'b0, rise8}, 32'd0);
        check("lat_cnt_e3", {24'b0, cnt8}, 32'd1);
        tick();
        check("lat_fall_e4", {31'b0, fall8}, 32'd1);
        tick();
        check("lat_fall_e5", {31'b0, fall8}, 32'd0);
        check("lat_cnt_end", {24'b0, cnt8}, 32'd1);
        check("lat_seen_end", {31'b0, seen8}, 32'd1);

        // Clear, then saturation on the 2-bit instance
        clr = 1;
        tick();
        clr = 0;
        check("clr_cnt", {24'b0, cnt8}, 32'd0);
        check("clr_seen", {31'b0, seen8}, 32'd0);
        check("clr_cnt2", {30'b0, cnt2}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            a = 4'b0001;
            ticks(3);
            a = 4'b0000;
            ticks(3);
            check($sformatf("sat_cnt2_%0d", i), {30'b0, cnt2}, (i < 3) ? i + 1 : 3);
            check($sformatf("sat_cnt8_%0d", i), {24'b0, cnt8}, i + 1);
        end

        // Clear asserted during the rise pulse
        a = 4'b0010;
        tick();
        tick();
        check("cp_rise", {31'b0, rise8}, 32'd1);
        clr = 1;
        tick();
        clr = 0;
        check("cp_cnt", {24'b0, cnt8}, 32'd0);
        check("cp_seen", {31'b0, seen8}, 32'd0);
        check("cp_zn_q", {31'b0, znq8}, 32'd1);

        // Build rise_cnt=2 with zn_q=1, then reset between edges
        a = 4'b0000; ticks(3);
        a = 4'b1000; ticks(3);
        a = 4'b0000; ticks(3);
        a = 4'b1000; ticks(3);
        check("ar_pre_cnt", {24'b0, cnt8}, 32'd2);
        check("ar_pre_zn_q", {31'b0, znq8}, 32'd1);
        #2 rst_n = 0;
        #1;
        check("ar_zn_q", {31'b0, znq8}, 32'd0);
        check("ar_cnt", {24'b0, cnt8}, 32'd0);
        check("ar_seen", {31'b0, seen8}, 32'd0);
        check("ar_zn", {31'b0, zn8}, 32'd1);

        // Release with all inputs high
        a = 4'b1111;
        #3 rst_n = 1;
        tick();
        check("rel_zn_q", {31'b0, znq8}, 32'd1);
        check("rel_rise_e1", {31'b0, rise8}, 32'd0);
        tick();
        check("rel_rise_e2", {31'b0, rise8}, 32'd1);
        tick();
        check("rel_rise_e3", {31'b0, rise8}, 32'd0);
        check("rel_cnt", {24'b0, cnt8}, 32'd1);
        tick();
        check("rel_cnt_hold", {24'b0, cnt8}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/or4_x1.md
OR4_X1 -- requirements
Module: or4_x1

Interface
REQ-001 Parameter CNT_W, default 8, width of the rising-edge event counter (legal range 2..16).
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low; synchronous deassert is the integrator's responsibility.
REQ-004 A1, A2, A3, A4  input  1 each  OR operands.
REQ-005 clr  input  1  synchronous clear of the counter and sticky flag, active-high.
REQ-006 ZN  output  1  combinational OR of A1..A4.
REQ-007 zn_q  output  1  ZN registered once.
REQ-008 rise  output  1  one-cycle pulse on a 0->1 transition of zn_q.
REQ-009 fall  output  1  one-cycle pulse on a 1->0 transition of zn_q.
REQ-010 rise_cnt  output  CNT_W  saturating count of rise pulses.
REQ-011 seen_high  output  1  sticky flag, set once zn_q has been 1.

Function
REQ-012 ZN SHALL equal A1|A2|A3|A4 with no clock dependency; it is 0 only for input 0000 and 1 for the other 15 codes.
REQ-013 ZN SHALL be valid with clk stopped and rst_n in either state.
REQ-014 zn_q SHALL take ZN at every rising clk edge, giving 1-cycle latency.
REQ-015 An internal register zn_d SHALL hold the previous zn_q.
REQ-016 rise SHALL be the registered value of (zn_q & ~zn_d), and fall SHALL be the registered value of (~zn_q & zn_d).
REQ-017 Each rise or fall pulse SHALL last exactly one cycle and appear 2 cycles after the ZN edge.
REQ-018 rise and fall SHALL never be high in the same cycle.
REQ-019 rise_cnt SHALL increment by 1 in the cycle after rise=1 and SHALL saturate at 2^CNT_W-1 with no wrap-around.
REQ-020 seen_high SHALL set in the cycle after zn_q=1 and SHALL hold until a clear or a reset.
REQ-021 clr=1 SHALL zero rise_cnt and seen_high at the next edge, and clr SHALL take priority over a simultaneous increment or set.
REQ-022 clr SHALL NOT affect ZN, zn_q, zn_d, rise or fall.
REQ-023 X or Z on any A input SHALL propagate to ZN per standard Verilog OR semantics; a 1 on any input SHALL force ZN=1.

Reset
REQ-024 While rst_n=0, zn_q, zn_d, rise, fall, rise_cnt and seen_high SHALL be 0 immediately, without waiting for clk.
REQ-025 Reset asserted mid-operation SHALL discard any pending pulse and clear the count.
REQ-026 ZN SHALL be unaffected by reset.
REQ-027 After rst_n rises, the first edge SHALL load zn_q, and no rise pulse SHALL be produced unless zn_q was 0 and then became 1 after reset.

Structure
REQ-028 No shared package is required; CNT_W SHALL be a module parameter only.
REQ-029 The combinational OR SHALL be a continuous assignment in the top module.
REQ-030 The edge detector, counter and sticky flag SHALL live in one sub-module, or4_x1_evt, with ports clk, rst_n, clr, d, rise, fall, cnt and seen.
REQ-031 Total RTL SHALL be 120-400 lines, including the sub-module.

Verification
REQ-032 Exhaustive truth table: with clk idle, apply all 16 codes A1A2A3A4 = 0000..1111, holding each for 10 time units -> ZN=0 for 0000 and ZN=1 for all other codes.
REQ-033 Latency: with rst_n=1, step the inputs 0000 -> 0100 -> 0000 -> outputs below.
  - zn_q is 1 one cycle after the first edge.
  - rise pulses one cycle after zn_q goes to 1.
  - fall pulses one cycle after zn_q returns to 0.
  - rise_cnt=1 and seen_high=1 afterwards.
REQ-034 Saturation: with CNT_W=2, toggle A4 five times -> rise_cnt stops at 3 and does not wrap to 0.
REQ-035 Clear priority: assert clr in the same cycle as a rise pulse -> rise_cnt=0 and seen_high=0 next cycle; zn_q is unchanged.
REQ-036 Asynchronous reset: drop rst_n between clk edges while rise_cnt=2 and zn_q=1.
  - zn_q, rise_cnt and seen_high go to 0 immediately.
  - ZN stays 1 while A inputs remain nonzero.
REQ-037 Reset release with A=1111 -> zn_q=1 after the first edge, followed by one rise pulse, and rise_cnt=1.
